// File: rtl/fore_mask_writer_if.sv
// Bundle for the mask writer: pixel decision stream, start/status and the
// frame-memory write bus. The writer is the bus master.
interface fore_mask_writer_if #(
    parameter int ADDR_W = 17
);
    logic              start_i;
    logic              rd_fore_i;
    logic [7:0]        fore_i;
    logic              mem_stb_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              mem_ack_i;
    logic              busy_o;
    logic              frame_done_o;
    logic [ADDR_W+1:0] fg_count_o;
    logic              overflow_o;

    modport master (
        input  start_i, rd_fore_i, fore_i, mem_ack_i,
        output mem_stb_o, mem_addr_o, mem_data_o, busy_o, frame_done_o,
               fg_count_o, overflow_o
    );

    modport slave (
        output start_i, rd_fore_i, fore_i, mem_ack_i,
        input  mem_stb_o, mem_addr_o, mem_data_o, busy_o, frame_done_o,
               fg_count_o, overflow_o
    );
endinterface

// File: rtl/fore_mask_writer.sv
// Packs per-pixel fg/bg decisions (normalised to FF/00) four to a word,
// buffers them in a small FIFO and writes them to frame memory via stb/ack.
module fore_mask_writer #(
    parameter int FRAME_PIXELS = 76800,
    parameter int BASE_ADDR    = 0,
    parameter int ADDR_W       = 17,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fore_mask_writer_if.master bus
);
    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  pix_cnt;
    logic [1:0]        lane;
    logic [31:0]       word_buf, word_nxt;
    logic [ADDR_W+1:0] fg_count;
    logic              overflow;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              stb;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;

    logic arm, take_pixel, last_pixel, frame_done;
    logic fg_pixel, push, pop, wr_en, drop, fifo_empty, fifo_full, accept;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign accept     = stb && bus.mem_ack_i;
    assign pop        = !fifo_empty && (!stb || bus.mem_ack_i);
    assign fg_pixel   = (bus.fore_i != 8'd0);
    assign push       = take_pixel && ((lane == 2'd3) || last_pixel);
    // A full FIFO still takes a word when the write port pops in the same cycle.
    assign wr_en      = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        arm        = 1'b0;
        take_pixel = 1'b0;
        last_pixel = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: if (bus.start_i) begin
                arm       = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (bus.rd_fore_i) begin
                take_pixel = 1'b1;
                if (pix_cnt == LAST_CNT) begin
                    last_pixel = 1'b1;
                    state_nxt  = FLUSH;
                end
            end
            FLUSH: if (fifo_empty && !stb) begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word_nxt = word_buf;
        word_nxt[{lane, 3'b000} +: 8] = fg_pixel ? 8'hFF : 8'h00;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_cnt  <= '0;
            lane     <= '0;
            word_buf <= '0;
            fg_count <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            stb      <= 1'b0;
            addr     <= BASE;
            data     <= '0;
        end else if (arm) begin
            pix_cnt  <= '0;
            lane     <= '0;
            word_buf <= '0;
            fg_count <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            addr     <= BASE;
        end else begin
            if (take_pixel) begin
                pix_cnt  <= pix_cnt + 1'b1;
                lane     <= lane + 1'b1;
                word_buf <= push ? '0 : word_nxt;
                if (fg_pixel) fg_count <= fg_count + 1'b1;
            end
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (drop)  overflow <= 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                data   <= fifo_mem[rd_ptr[PTR_W-1:0]];
                stb    <= 1'b1;
            end else if (accept) begin
                stb <= 1'b0;
            end
            if (accept) addr <= addr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) fifo_mem[wr_ptr[PTR_W-1:0]] <= word_nxt;
    end

    assign bus.mem_stb_o    = stb;
    assign bus.mem_addr_o   = addr;
    assign bus.mem_data_o   = data;
    assign bus.busy_o       = (state != IDLE);
    assign bus.frame_done_o = frame_done;
    assign bus.fg_count_o   = fg_count;
    assign bus.overflow_o   = overflow;
endmodule
